// File: rtl/sdram_burst_arbiter_pkg.sv
// Shared types and helpers for the SDRAM burst arbiter: FSM state, default channel
// counts and the slot-to-direction mapping (read slots first, then write slots).
package sdram_arb_pkg;

  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;
  localparam int SLOT_W     = $clog2(DEF_NUM_RD + DEF_NUM_WR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  function automatic logic slot_is_write(input int slot, input int num_rd);
    return (slot >= num_rd) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/sdram_burst_arbiter_if.sv
// Channel-side and core-side burst buses of the arbiter. The arbiter uses the slave
// modport; the environment (channels plus sdram_core) uses the master modport.
interface sdram_burst_arbiter_if #(
  parameter int MEM_DATA_BITS = 16,
  parameter int ADDR_BITS     = 24,
  parameter int BURST_BITS    = 10,
  parameter int NUM_RD        = 2,
  parameter int NUM_WR        = 2
);
  logic [NUM_RD-1:0]               ch_rd_req;
  logic [NUM_RD*BURST_BITS-1:0]    ch_rd_len;
  logic [NUM_RD*ADDR_BITS-1:0]     ch_rd_addr;
  logic [NUM_RD-1:0]               ch_rd_data_valid;
  logic [MEM_DATA_BITS-1:0]        ch_rd_data;
  logic [NUM_RD-1:0]               ch_rd_finish;
  logic [NUM_WR-1:0]               ch_wr_req;
  logic [NUM_WR*BURST_BITS-1:0]    ch_wr_len;
  logic [NUM_WR*ADDR_BITS-1:0]     ch_wr_addr;
  logic [NUM_WR-1:0]               ch_wr_data_req;
  logic [NUM_WR*MEM_DATA_BITS-1:0] ch_wr_data;
  logic [NUM_WR-1:0]               ch_wr_finish;

  logic                     rd_burst_req;
  logic [BURST_BITS-1:0]    rd_burst_len;
  logic [ADDR_BITS-1:0]     rd_burst_addr;
  logic                     rd_burst_data_valid;
  logic [MEM_DATA_BITS-1:0] rd_burst_data;
  logic                     rd_burst_finish;
  logic                     wr_burst_req;
  logic [BURST_BITS-1:0]    wr_burst_len;
  logic [ADDR_BITS-1:0]     wr_burst_addr;
  logic                     wr_burst_data_req;
  logic [MEM_DATA_BITS-1:0] wr_burst_data;
  logic                     wr_burst_finish;

  modport slave (
    input  ch_rd_req, ch_rd_len, ch_rd_addr,
    output ch_rd_data_valid, ch_rd_data, ch_rd_finish,
    input  ch_wr_req, ch_wr_len, ch_wr_addr, ch_wr_data,
    output ch_wr_data_req, ch_wr_finish,
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  rd_burst_data_valid, rd_burst_data, rd_burst_finish,
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  wr_burst_data_req, wr_burst_finish
  );

  modport master (
    output ch_rd_req, ch_rd_len, ch_rd_addr,
    input  ch_rd_data_valid, ch_rd_data, ch_rd_finish,
    output ch_wr_req, ch_wr_len, ch_wr_addr, ch_wr_data,
    input  ch_wr_data_req, ch_wr_finish,
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output rd_burst_data_valid, rd_burst_data, rd_burst_finish,
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output wr_burst_data_req, wr_burst_finish
  );
endinterface

// File: rtl/sdram_burst_arbiter_rr_pick.sv
// Round-robin picker: index of the first set request bit at or after ptr, wrapping.
// ptr must be below N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          found
);

  logic [N-1:0] shifted_s;
  int           slot_s;

  // Scan all slots starting at ptr and keep the first requester
  always_comb begin
    idx       = '0;
    found     = 1'b0;
    shifted_s = '0;
    slot_s    = 0;
    for (int i = 0; i < N; i++) begin
      slot_s = int'(ptr) + i;
      if (slot_s >= N) begin
        slot_s = slot_s - N;
      end else begin
        slot_s = slot_s;
      end
      shifted_s = req >> slot_s;
      if (!found && shifted_s[0]) begin
        found = 1'b1;
        idx   = PW'(slot_s);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Shares one sdram_core burst port among NUM_RD read and NUM_WR write channels, one whole
// burst per grant. Optional macro READ_PRIORITY_EN: reads beat writes, round-robin per group.
module sdram_burst_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int MEM_DATA_BITS = 16,
  parameter int ADDR_BITS     = 24,
  parameter int BURST_BITS    = 10,
  parameter int NUM_RD        = DEF_NUM_RD,
  parameter int NUM_WR        = DEF_NUM_WR
) (
  input logic               clk,
  input logic               rst,
  sdram_burst_arbiter_if.slave bus
);

  localparam int NS = NUM_RD + NUM_WR;
  localparam int SW = $clog2(NS);

  arb_state_t               state_r, state_s;
  logic [SW-1:0]            grant_r, rr_ptr_r, pick_s;
  logic                     pick_found_s, pick_wr_s, grant_wr_s, core_fin_s;
  logic [BURST_BITS-1:0]    len_r, pick_len_s;
  logic [ADDR_BITS-1:0]     addr_r, pick_addr_s;
  logic                     rd_req_r, wr_req_r;
  int                       grant_ch_s, pick_ch_s;
  logic [NUM_RD-1:0]        rd_valid_s, rd_fin_s;
  logic [NUM_WR-1:0]        wr_dreq_s, wr_fin_s;
  logic [MEM_DATA_BITS-1:0] wr_data_s;

  assign grant_wr_s = slot_is_write(int'(grant_r), NUM_RD);
  assign grant_ch_s = grant_wr_s ? (int'(grant_r) - NUM_RD) : int'(grant_r);
  // Only a finish of the granted direction while busy ends the burst
  assign core_fin_s = (state_r == BUSY) &&
                      (grant_wr_s ? bus.wr_burst_finish : bus.rd_burst_finish);

`ifdef READ_PRIORITY_EN
  localparam int RPW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int WPW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  logic [RPW-1:0] rd_ptr_r, rd_idx_s;
  logic [WPW-1:0] wr_ptr_r, wr_idx_s;
  logic           rd_found_s, wr_found_s;

  rr_pick #(.N(NUM_RD), .PW(RPW)) u_rd_pick (
    .req(bus.ch_rd_req), .ptr(rd_ptr_r), .idx(rd_idx_s), .found(rd_found_s)
  );
  rr_pick #(.N(NUM_WR), .PW(WPW)) u_wr_pick (
    .req(bus.ch_wr_req), .ptr(wr_ptr_r), .idx(wr_idx_s), .found(wr_found_s)
  );

  // Any pending read wins over every write
  always_comb begin
    pick_s       = '0;
    pick_found_s = 1'b0;
    if (rd_found_s) begin
      pick_s       = SW'(rd_idx_s);
      pick_found_s = 1'b1;
    end else if (wr_found_s) begin
      pick_s       = SW'(int'(wr_idx_s) + NUM_RD);
      pick_found_s = 1'b1;
    end else begin
      pick_s       = '0;
      pick_found_s = 1'b0;
    end
  end

  // Per-group round-robin pointers advance past the finished channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
    end else if (core_fin_s && grant_wr_s) begin
      wr_ptr_r <= (grant_ch_s == NUM_WR - 1) ? '0 : WPW'(grant_ch_s + 1);
    end else if (core_fin_s) begin
      rd_ptr_r <= (grant_ch_s == NUM_RD - 1) ? '0 : RPW'(grant_ch_s + 1);
    end else begin
      rd_ptr_r <= rd_ptr_r;
      wr_ptr_r <= wr_ptr_r;
    end
  end
`else
  rr_pick #(.N(NS), .PW(SW)) u_pick (
    .req({bus.ch_wr_req, bus.ch_rd_req}), .ptr(rr_ptr_r), .idx(pick_s), .found(pick_found_s)
  );
`endif

  // Length and address of the slot that would be granted this cycle
  always_comb begin
    pick_wr_s   = slot_is_write(int'(pick_s), NUM_RD);
    pick_ch_s   = 0;
    pick_len_s  = '0;
    pick_addr_s = '0;
    if (pick_wr_s) begin
      pick_ch_s   = int'(pick_s) - NUM_RD;
      pick_len_s  = BURST_BITS'(bus.ch_wr_len >> (pick_ch_s * BURST_BITS));
      pick_addr_s = ADDR_BITS'(bus.ch_wr_addr >> (pick_ch_s * ADDR_BITS));
    end else begin
      pick_ch_s   = int'(pick_s);
      pick_len_s  = BURST_BITS'(bus.ch_rd_len >> (pick_ch_s * BURST_BITS));
      pick_addr_s = ADDR_BITS'(bus.ch_rd_addr >> (pick_ch_s * ADDR_BITS));
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: GAP guarantees one low cycle so the core sees a fresh req edge
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = pick_found_s ? BUSY : IDLE;
      BUSY:    state_s = core_fin_s ? GAP : BUSY;
      GAP:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Grant capture, core request hold and global round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_r  <= '0;
      len_r    <= '0;
      addr_r   <= '0;
      rd_req_r <= 1'b0;
      wr_req_r <= 1'b0;
      rr_ptr_r <= '0;
    end else if ((state_r == IDLE) && pick_found_s) begin
      grant_r  <= pick_s;
      len_r    <= pick_len_s;
      addr_r   <= pick_addr_s;
      rd_req_r <= ~pick_wr_s;
      wr_req_r <= pick_wr_s;
    end else if (core_fin_s) begin
      rd_req_r <= 1'b0;
      wr_req_r <= 1'b0;
      rr_ptr_r <= (int'(grant_r) == NS - 1) ? '0 : grant_r + SW'(1);
    end else begin
      rd_req_r <= rd_req_r;
      wr_req_r <= wr_req_r;
    end
  end

  // Route core handshakes and finish to the granted channel only
  always_comb begin
    rd_valid_s = '0;
    rd_fin_s   = '0;
    wr_dreq_s  = '0;
    wr_fin_s   = '0;
    wr_data_s  = '0;
    if ((state_r == BUSY) && grant_wr_s) begin
      wr_dreq_s = NUM_WR'(bus.wr_burst_data_req) << grant_ch_s;
      wr_fin_s  = NUM_WR'(bus.wr_burst_finish) << grant_ch_s;
      wr_data_s = MEM_DATA_BITS'(bus.ch_wr_data >> (grant_ch_s * MEM_DATA_BITS));
    end else if (state_r == BUSY) begin
      rd_valid_s = NUM_RD'(bus.rd_burst_data_valid) << grant_ch_s;
      rd_fin_s   = NUM_RD'(bus.rd_burst_finish) << grant_ch_s;
    end else begin
      rd_valid_s = '0;
      wr_dreq_s  = '0;
    end
  end

  assign bus.rd_burst_req     = rd_req_r;
  assign bus.rd_burst_len     = len_r;
  assign bus.rd_burst_addr    = addr_r;
  assign bus.wr_burst_req     = wr_req_r;
  assign bus.wr_burst_len     = len_r;
  assign bus.wr_burst_addr    = addr_r;
  assign bus.wr_burst_data    = wr_data_s;
  assign bus.ch_rd_data_valid = rd_valid_s;
  assign bus.ch_rd_data       = bus.rd_burst_data;
  assign bus.ch_rd_finish     = rd_fin_s;
  assign bus.ch_wr_data_req   = wr_dreq_s;
  assign bus.ch_wr_finish     = wr_fin_s;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Self-checking bench: the bench plays the channels and sdram_core, and predicts each
// grant from a slot-level round-robin model (read-first when READ_PRIORITY_EN is set).
module tb_sdram_burst_arbiter;

  localparam int MDB = 16, AB = 24, BB = 10, NUM_RD = 2, NUM_WR = 2, NS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_burst_arbiter_if #(.MEM_DATA_BITS(MDB), .ADDR_BITS(AB), .BURST_BITS(BB),
                           .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

  sdram_burst_arbiter #(.MEM_DATA_BITS(MDB), .ADDR_BITS(AB), .BURST_BITS(BB),
                        .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int m_ptr = 0, m_rd_ptr = 0, m_wr_ptr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NS-1:0] pend();
    return {bus.ch_wr_req, bus.ch_rd_req};
  endfunction

  // Reference arbitration: first pending slot at/after the pointer, wrapping
  function automatic int model_pick(input logic [NS-1:0] p);
    int s;
`ifdef READ_PRIORITY_EN
    for (int i = 0; i < NUM_RD; i++) begin
      s = (m_rd_ptr + i) % NUM_RD;
      if (((p >> s) & NS'(1)) != '0) return s;
    end
    for (int i = 0; i < NUM_WR; i++) begin
      s = (m_wr_ptr + i) % NUM_WR;
      if (((p >> (NUM_RD + s)) & NS'(1)) != '0) return NUM_RD + s;
    end
`else
    for (int i = 0; i < NS; i++) begin
      s = (m_ptr + i) % NS;
      if (((p >> s) & NS'(1)) != '0) return s;
    end
`endif
    return -1;
  endfunction

  task automatic model_granted(input int g);
    m_ptr = (g + 1) % NS;
    if (g < NUM_RD) m_rd_ptr = (g + 1) % NUM_RD;
    else            m_wr_ptr = (g - NUM_RD + 1) % NUM_WR;
  endtask

  task automatic set_ch(input int slot, input int len, input logic [AB-1:0] addr, input logic req);
    if (slot < NUM_RD) begin
      bus.ch_rd_len[slot*BB +: BB]  = BB'(len);
      bus.ch_rd_addr[slot*AB +: AB] = addr;
      bus.ch_rd_req[slot +: 1]      = req;
    end else begin
      bus.ch_wr_len[(slot-NUM_RD)*BB +: BB]  = BB'(len);
      bus.ch_wr_addr[(slot-NUM_RD)*AB +: AB] = addr;
      bus.ch_wr_req[(slot-NUM_RD) +: 1]      = req;
    end
  endtask

  task automatic clear_core();
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_data       = '0;
    bus.rd_burst_finish     = 1'b0;
    bus.wr_burst_data_req   = 1'b0;
    bus.wr_burst_finish     = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_core_req"}, 64'({bus.rd_burst_req, bus.wr_burst_req}), 64'd0);
    chk({tag, "_len_addr"}, 64'({bus.rd_burst_len, bus.rd_burst_addr, bus.wr_burst_len}), 64'd0);
    chk({tag, "_wr_addr"}, 64'(bus.wr_burst_addr), 64'd0);
    chk({tag, "_ch_out"}, 64'({bus.ch_rd_data_valid, bus.ch_rd_finish,
                               bus.ch_wr_data_req, bus.ch_wr_finish}), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ch_rd_req = '0; bus.ch_rd_len = '0; bus.ch_rd_addr = '0;
    bus.ch_wr_req = '0; bus.ch_wr_len = '0; bus.ch_wr_addr = '0; bus.ch_wr_data = '0;
    clear_core();
    tick();
    tick();
    check_outputs_zero("reset");
    #3 rst = 1'b0;
    m_ptr = 0; m_rd_ptr = 0; m_wr_ptr = 0;
  endtask

  // Wait for the predicted grant, stream its beats as the core, then finish it
  task automatic serve(input bit drop_done, input bit mutate, input logic [NS-1:0] raise,
                       output int g, output int lowc);
    bit isw;
    int ch, n, waited;
    logic [BB-1:0] elen;
    logic [AB-1:0] eaddr;
    logic [MDB-1:0] d;
    g = model_pick(pend());
    lowc = 0;
    if (g < 0) begin
      checks++; errors++;
      $error("FAIL serve_no_pending observed=none expected=a pending slot");
      return;
    end
    isw = (g >= NUM_RD);
    ch = isw ? g - NUM_RD : g;
    elen  = isw ? BB'(bus.ch_wr_len >> (ch*BB)) : BB'(bus.ch_rd_len >> (ch*BB));
    eaddr = isw ? AB'(bus.ch_wr_addr >> (ch*AB)) : AB'(bus.ch_rd_addr >> (ch*AB));
    waited = 0;
    while (!(bus.rd_burst_req || bus.wr_burst_req) && waited < 40) begin
      tick();
      waited++;
    end
    lowc = waited;
    if (!(bus.rd_burst_req || bus.wr_burst_req)) begin
      checks++; errors++;
      $error("FAIL grant_timeout observed=no core req expected=slot %0d", g);
      return;
    end
    chk($sformatf("grant_dir_slot%0d", g), 64'({bus.rd_burst_req, bus.wr_burst_req}),
        isw ? 64'd1 : 64'd2);
    chk($sformatf("grant_len_slot%0d", g), 64'(isw ? bus.wr_burst_len : bus.rd_burst_len), 64'(elen));
    model_granted(g);
    n = int'(elen);
    for (int b = 0; b < n; b++) begin
      if (isw) begin
        for (int k = 0; k < NUM_WR; k++) bus.ch_wr_data[k*MDB +: MDB] = MDB'($urandom);
        bus.wr_burst_data_req = 1'b1;
        bus.rd_burst_finish   = (b == 0);
      end else begin
        d = MDB'($urandom);
        bus.rd_burst_data       = d;
        bus.rd_burst_data_valid = 1'b1;
        bus.wr_burst_finish     = (b == 0);
      end
      if (b == n / 2) begin
        bus.ch_rd_req = bus.ch_rd_req | raise[NUM_RD-1:0];
        bus.ch_wr_req = bus.ch_wr_req | raise[NS-1:NUM_RD];
        if (mutate) set_ch(g, n, ~eaddr, 1'b0);
      end
      #1;
      if (isw) begin
        chk("wr_data_req_route", 64'(bus.ch_wr_data_req), 64'd1 << ch);
        chk("wr_data_mux", 64'(bus.wr_burst_data), 64'(MDB'(bus.ch_wr_data >> (ch*MDB))));
        chk("wrong_dir_fin_ignored", 64'(bus.ch_rd_finish), 64'd0);
      end else begin
        chk("rd_valid_route", 64'(bus.ch_rd_data_valid), 64'd1 << ch);
        chk("rd_data_bcast", 64'(bus.ch_rd_data), 64'(d));
        chk("wrong_dir_fin_ignored", 64'(bus.ch_wr_finish), 64'd0);
      end
      chk("core_addr_latched", 64'(isw ? bus.wr_burst_addr : bus.rd_burst_addr), 64'(eaddr));
      tick();
    end
    clear_core();
    if (isw) bus.wr_burst_finish = 1'b1;
    else     bus.rd_burst_finish = 1'b1;
    if (drop_done) set_ch(g, n, eaddr, 1'b0);
    #1;
    chk("req_held_to_finish", 64'({bus.rd_burst_req, bus.wr_burst_req}), isw ? 64'd1 : 64'd2);
    chk($sformatf("finish_slot%0d", g), 64'({bus.ch_wr_finish, bus.ch_rd_finish}), 64'd1 << g);
    tick();
    clear_core();
    chk("gap_req_low", 64'({bus.rd_burst_req, bus.wr_burst_req}), 64'd0);
  endtask

  int g, lowc, guard;

  initial begin
    do_reset();

    // Single read: 480 beats, latency one cycle
    set_ch(0, 480, 24'h000100, 1'b1);
    serve(1'b1, 1'b0, '0, g, lowc);
    chk("rd0_grant_latency", 64'(lowc), 64'd1);

    // Spurious finishes in IDLE
    tick();
    bus.rd_burst_finish = 1'b1;
    bus.wr_burst_finish = 1'b1;
    #1;
    chk("spurious_fin_idle", 64'({bus.ch_rd_finish, bus.ch_wr_finish}), 64'd0);
    tick();
    clear_core();
    chk("spurious_fin_no_req", 64'({bus.rd_burst_req, bus.wr_burst_req}), 64'd0);
    set_ch(1, 7, 24'h0A0B0C, 1'b1);
    serve(1'b1, 1'b0, '0, g, lowc);
    chk("after_spurious_latency", 64'(lowc), 64'd1);

    // All four requesting and held: fair order with a 2-cycle idle spacing
    do_reset();
    for (int s = 0; s < NS; s++) set_ch(s, 2 + s, AB'(24'h100000 + s * 24'h1111), 1'b1);
    for (int k = 0; k < 5; k++) begin
      serve(1'b0, 1'b0, '0, g, lowc);
      if (k > 0) chk($sformatf("burst_spacing_%0d", k), 64'(lowc), 64'd2);
    end
    bus.ch_rd_req = '0;
    bus.ch_wr_req = '0;
    tick();
    tick();

    // Granted write ch1 changes its address and drops req mid-burst
    set_ch(3, 6, 24'h3C3C3C, 1'b1);
    serve(1'b0, 1'b1, '0, g, lowc);
    tick();

    // Both writes pending, rd1 rises during the first write burst
    set_ch(2, 4, 24'h200200, 1'b1);
    set_ch(3, 5, 24'h300300, 1'b1);
    set_ch(1, 3, 24'h111111, 1'b0);
    serve(1'b1, 1'b0, 4'b0010, g, lowc);
    guard = 0;
    while (pend() != '0 && guard < 10) begin
      serve(1'b1, 1'b0, '0, g, lowc);
      guard++;
    end

    // Reset at data beat 100 of a 256-beat read
    do_reset();
    set_ch(0, 256, 24'h0F0F00, 1'b1);
    guard = 0;
    while (!bus.rd_burst_req && guard < 10) begin tick(); guard++; end
    chk("mid_reset_burst_started", 64'(bus.rd_burst_req), 64'd1);
    for (int b = 0; b < 100; b++) begin
      bus.rd_burst_data_valid = 1'b1;
      bus.rd_burst_data = MDB'(b);
      tick();
    end
    set_ch(0, 256, 24'h0F0F00, 1'b0);
    set_ch(1, 3, 24'h0000A1, 1'b1);
    set_ch(2, 4, 24'h0000B2, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    clear_core();
    tick();
    tick();
    #3 rst = 1'b0;
    m_ptr = 0; m_rd_ptr = 0; m_wr_ptr = 0;
    serve(1'b1, 1'b0, '0, g, lowc);
    chk("post_reset_latency", 64'(lowc), 64'd1);
    serve(1'b1, 1'b0, '0, g, lowc);

    // Randomized request patterns against the model
    for (int r = 0; r < 30; r++) begin
      tick();
      for (int s = 0; s < NS; s++) begin
        if ((((pend() >> s) & NS'(1)) == '0) && ($urandom_range(1, 0) == 1))
          set_ch(s, 1 + $urandom_range(5, 0), AB'($urandom), 1'b1);
      end
      guard = 0;
      while (pend() != '0 && guard < 12) begin
        serve(1'b1, 1'b0, '0, g, lowc);
        if ($urandom_range(3, 0) == 0) begin
          int s = $urandom_range(NS - 1, 0);
          if (s < NUM_RD) bus.ch_rd_req[s +: 1] = 1'b0;
          else            bus.ch_wr_req[(s - NUM_RD) +: 1] = 1'b0;
        end
        guard++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
